// File: rtl/jh_header_streamer_if.sv
// rtl/jh_header_streamer_if.sv - Avalon-MM register bus plus hash-core source handshake.
interface jh_header_streamer_if;
   logic [4:0]  address;
   logic [31:0] writedata;
   logic        write;
   logic        read;
   logic        chipselect;
   logic [31:0] readdata;
   logic [63:0] out_data;
   logic        out_empty;
   logic        out_read;
   logic        hash_done;

   modport master (
      output address, writedata, write, read, chipselect, out_read, hash_done,
      input  readdata, out_data, out_empty
   );

   modport slave (
      input  address, writedata, write, read, chipselect, out_read, hash_done,
      output readdata, out_data, out_empty
   );
endinterface

// File: rtl/jh_header_streamer.sv
// rtl/jh_header_streamer.sv - header RAM streamer feeding the JH hash core source port.
// Define JH_STREAM_AUTONONCE_EN to re-stream with nonce+1 for each remaining run.
module jh_header_streamer #(
   parameter int HDR_WORDS  = 10,
   parameter int NONCE_WORD = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   jh_header_streamer_if.slave   bus
);
   localparam int         IW        = $clog2(HDR_WORDS);
   localparam logic [4:0] A_HDR_END = 5'(2 * HDR_WORDS);
   localparam logic [4:0] A_CTRL    = 5'h14;
   localparam logic [4:0] A_RUNCNT  = 5'h15;
   localparam logic [4:0] A_STATUS  = 5'h16;
   localparam logic [4:0] A_NONCE   = 5'h17;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_HASH} state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [63:0]   r_hdr [HDR_WORDS];
   logic [IW-1:0] r_index;
   logic [31:0]   r_nonce;
   logic [31:0]   r_run_count;
   logic [31:0]   r_readdata;
   logic          r_done_sticky;
`ifdef JH_STREAM_AUTONONCE_EN
   logic [31:0]   r_remaining;
   logic          w_restream;
`endif

   logic          w_wr;
   logic          w_rd;
   logic          w_hdr_sel;
   logic [IW-1:0] w_hdr_idx;
   logic          w_ctrl_wr;
   logic          w_start;
   logic          w_abort;
   logic          w_pop;
   logic          w_last;
   logic          w_finish;
   logic [63:0]   w_word;

   assign w_wr      = bus.chipselect & bus.write;
   assign w_rd      = bus.chipselect & bus.read;
   assign w_hdr_sel = (bus.address < A_HDR_END);
   assign w_hdr_idx = bus.address[IW:1];
   assign w_ctrl_wr = w_wr && (bus.address == A_CTRL);
   // Abort outranks start when both bits are written together.
   assign w_abort   = w_ctrl_wr & bus.writedata[1];
   assign w_start   = w_ctrl_wr & bus.writedata[0] & ~bus.writedata[1] & (r_state == S_IDLE);
   assign w_last    = (r_index == IW'(HDR_WORDS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_finish     = 1'b0;
`ifdef JH_STREAM_AUTONONCE_EN
      w_restream   = 1'b0;
`endif
      if (w_abort) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) w_next_state = S_STREAM;
            end
            S_STREAM: begin
               if (bus.out_read) begin
                  w_pop = 1'b1;
                  if (w_last) w_next_state = S_WAIT_HASH;
               end
            end
            S_WAIT_HASH: begin
               if (bus.hash_done) begin
`ifdef JH_STREAM_AUTONONCE_EN
                  if (r_remaining > 32'd1) begin
                     w_restream   = 1'b1;
                     w_next_state = S_STREAM;
                  end else begin
                     w_finish     = 1'b1;
                     w_next_state = S_IDLE;
                  end
`else
                  w_finish     = 1'b1;
                  w_next_state = S_IDLE;
`endif
               end
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_index       <= '0;
         r_nonce       <= '0;
         r_run_count   <= 32'd1;
         r_done_sticky <= 1'b0;
`ifdef JH_STREAM_AUTONONCE_EN
         r_remaining   <= '0;
`endif
      end else begin
         if (w_wr && (bus.address == A_RUNCNT)) r_run_count <= bus.writedata;
         if (w_abort) begin
            r_index <= '0;
         end else if (w_start) begin
            r_index       <= '0;
            r_nonce       <= r_hdr[NONCE_WORD][63:32];
            r_done_sticky <= 1'b0;
`ifdef JH_STREAM_AUTONONCE_EN
            r_remaining   <= (r_run_count == 32'd0) ? 32'd1 : r_run_count;
`endif
         end else if (w_pop) begin
            r_index <= w_last ? '0 : r_index + IW'(1);
`ifdef JH_STREAM_AUTONONCE_EN
         end else if (w_restream) begin
            r_index     <= '0;
            r_nonce     <= r_nonce + 32'd1;
            r_remaining <= r_remaining - 32'd1;
`endif
         end else if (w_finish) begin
            r_done_sticky <= 1'b1;
         end
      end
   end

   // Header RAM deliberately survives reset; software reloads it only when it changes.
   always_ff @(posedge clk) begin
      if (w_wr && w_hdr_sel && (r_state == S_IDLE)) begin
         if (bus.address[0]) r_hdr[w_hdr_idx][63:32] <= bus.writedata;
         else                r_hdr[w_hdr_idx][31:0]  <= bus.writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= '0;
      end else if (w_rd) begin
         if (w_hdr_sel) begin
            r_readdata <= bus.address[0] ? r_hdr[w_hdr_idx][63:32] : r_hdr[w_hdr_idx][31:0];
         end else begin
            case (bus.address)
               A_RUNCNT: r_readdata <= r_run_count;
               A_STATUS: r_readdata <= {29'd0, r_done_sticky, (r_state == S_STREAM), (r_state != S_IDLE)};
               A_NONCE:  r_readdata <= r_nonce;
               default:  r_readdata <= '0;
            endcase
         end
      end
   end

   always_comb begin
      w_word = r_hdr[r_index];
      if (r_index == IW'(NONCE_WORD)) w_word[63:32] = r_nonce;
   end

   assign bus.out_data  = w_word;
   assign bus.out_empty = (r_state != S_STREAM);
   assign bus.readdata  = r_readdata;
endmodule

// File: doc/jh_header_streamer.md
# jh_header_streamer

Upstream feeder for the JH hash core's 64-bit source port. An Avalon-MM slave holds an 80-byte block header as ten 64-bit words. On start it presents the words one at a time through a FIFO-style empty/read handshake that drives the hash core's `src_ready`/`src_read` pair. After each completed hash it optionally advances the 32-bit nonce and re-streams, so software issues one command per nonce batch.

## Interface
Parameters:
- `HDR_WORDS`, 10: 64-bit words per header.
- `NONCE_WORD`, 9: word index carrying the nonce in bits [63:32].

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `address`  in  5  Avalon word address.
- `writedata`  in  32  Avalon write data.
- `write`  in  1  Avalon write strobe.
- `read`  in  1  Avalon read strobe.
- `chipselect`  in  1  Avalon select; qualifies `read` and `write`.
- `readdata`  out  32  registered read data.
- `out_data`  out  64  current header word (nonce substituted); feeds the hash core's `din`.
- `out_empty`  out  1  high = no word available; feeds the hash core's `src_ready`.
- `out_read`  in  1  pop strobe from the hash core's `src_read`.
- `hash_done`  in  1  one-cycle pulse when the downstream digest is complete.

## Operation
Register map (access = `chipselect` and `write`/`read`):
- 0x00–0x13 header RAM: address 2i = word i [31:0], address 2i+1 = word i [63:32]. Writes are ignored while busy. Reads return stored content.
- 0x14 control, write only:
  - bit0 start: ignored while busy.
  - bit1 abort: takes priority over start.
- 0x15 run count, R/W, 32 bits. A value of 0 is treated as 1.
- 0x16 status, read only: bit0 busy (state ≠ IDLE), bit1 streaming (state = STREAM), bit2 done_sticky.
  - done_sticky is cleared by start.
  - done_sticky is set on the return to IDLE after a run completes.
  - Abort does not set done_sticky.
- 0x17 current nonce, read only.
- Unmapped addresses read 0.

State machine, IDLE / STREAM / WAIT_HASH:
- IDLE → STREAM on start.
  - Word index is set to 0.
  - Nonce is loaded from header word `NONCE_WORD` [63:32].
  - Remaining count is loaded from run count.
- STREAM:
  - `out_empty`=0.
  - `out_data` = header[index]; at `NONCE_WORD`, bits [63:32] are replaced by the nonce register.
  - `out_read`=1 advances the index.
  - Popping word `HDR_WORDS`-1 → WAIT_HASH.
- WAIT_HASH: `out_empty`=1. On `hash_done`:
  - If autonce is compiled in and remaining > 1: nonce += 1 (32-bit wrap, 0xFFFFFFFF → 0), remaining −= 1, index ← 0, → STREAM.
  - Otherwise → IDLE and done_sticky is set.
- Abort from any state → IDLE. No done_sticky.

Boundary conditions:
- `out_read` while `out_empty`=1 is ignored.
- `hash_done` outside WAIT_HASH is ignored.
- A reset mid-stream returns the block to IDLE. The header RAM is not cleared by reset.

## Timing
Reset values:
- `readdata`=0, `out_empty`=1.
- State IDLE, index 0, nonce 0, run count 1, done_sticky 0.

Cycle behaviour:
- Start written at cycle T → `out_empty`=0 and word 0 on `out_data` at T+1.
- `out_data` is a combinational mux of index. A pop at cycle C presents the next word at C+1. Sustained throughput is one word per cycle.
- The pop of the last word at C → `out_empty`=1 at C+1.
- `hash_done` at D, with an autonce restream → `out_empty`=0 with word 0 at D+1.
- `readdata` is updated one cycle after a qualified read and holds its value otherwise.
- A header write and start in the same cycle are impossible: there is a single address per cycle.

## Configuration
- `JH_STREAM_AUTONONCE_EN` defined: WAIT_HASH re-streams with nonce+1 until the run count is exhausted. The nonce register and 0x17 reflect the nonce in flight.
- Not defined: every start streams exactly one header. Run count is still writable and readable but has no effect. Nonce equals the header's stored nonce.

## Test plan
- One-shot:
  - Stimulus: load words 0..9 = 0x0000000i_1000000i, start, pop each cycle.
  - Response: exactly ten words in order, `out_empty`=1 after the tenth; `hash_done` → status 0x4.
- Autonce (macro defined):
  - Stimulus: header nonce 0x00000005, run count 3, pulse `hash_done` after each stream.
  - Response: word 9 [63:32] = 5, 6, 7 on the three passes; then IDLE.
- Nonce wrap:
  - Stimulus: nonce 0xFFFFFFFF, run count 2.
  - Response: second pass carries 0x00000000.
- Abort:
  - Stimulus: abort after 4 pops.
  - Response: `out_empty`=1 next cycle, status 0x0. A new start restreams from word 0.
- Handshake:
  - Stimulus: `out_read` held high in IDLE and WAIT_HASH; stall pops for 5 cycles mid-stream.
  - Response: no index change while empty; `out_data` stable during the stall.
- Lockout:
  - Stimulus: header write of 0xDEADBEEF to 0x00 while busy.
  - Response: readback shows the original value; start while busy has no effect.
